bus_arb: RTL and testbench
==========================

Name: bus_arb

Overview:
- Sequential arbiter that shares one single-port synchronous memory between the instruction-fetch requester (PC/IF) and the data requester (MEM load/store).
- Sits between the core's fetch/MEM stages and the unified memory.
- Grants one access at a time, tracks memory read latency, returns data with a one-cycle ready pulse, and raises a stall request toward stall_ctl while any requester is waiting.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from m_en to m_rdata valid; legal range 1..7.
- STARVE_MAX, 4, number of consecutive data grants after which a pending fetch is granted first.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_re  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid only while if_ready=1.
- if_ready  out  1  one-cycle fetch completion pulse.
- d_re  in  1  data read request; held until d_ready.
- d_we  in  1  data write request; held until d_ready.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid only while d_ready=1.
- d_ready  out  1  one-cycle data completion pulse.
- m_en  out  1  memory access strobe; one cycle per access.
- m_we  out  1  memory write enable; qualified by m_en.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- stallreq_o  out  1  pipeline stall request to stall_ctl.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - FSM enters IDLE; latency counter and starve counter clear.
  - Any in-flight access is abandoned; its m_rdata is never forwarded.
- FSM states:
  - IDLE: no access outstanding.
  - ISSUE: m_en driven this cycle.
  - WAIT: counting read latency.
  - DONE: ready pulse.
- IDLE -> ISSUE on the same clock edge at which any request is sampled high; the grant is decided and latched on that edge.
- Grant rule:
  - Data wins over fetch.
  - Exception: if starve_cnt==STARVE_MAX and if_re=1, fetch wins.
  - starve_cnt increments on each data grant made while if_re=1, saturating at STARVE_MAX.
  - starve_cnt clears on any fetch grant, and on a data grant made while if_re=0.
- d_re and d_we both high: treated as a write.
- ISSUE (exactly one cycle):
  - m_en=1; m_addr and m_we/m_wdata come from the granted requester's latched values.
  - m_we=1 only for a data write.
  - Write: ISSUE -> DONE.
  - Read: ISSUE -> WAIT, loading lat_cnt=MEM_LAT-1.
- WAIT:
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, capture m_rdata into the granted side's rdata register and go to DONE.
  - MEM_LAT=1: WAIT lasts one cycle; capture happens on that cycle's edge.
- DONE (one cycle):
  - Granted side's ready=1 with rdata valid.
  - Next state is IDLE; no back-to-back issue from DONE.
- Latency from request sampled to ready pulse:
  - Read: MEM_LAT+2 cycles.
  - Write: 2 cycles.
- rdata holds its last value outside the ready pulse. Consumers must use it only while ready=1.
- If a requester drops its request after the grant, the access still completes, the ready pulse is still emitted, and the requester ignores it.
- m_en is never asserted outside ISSUE.
- stallreq_o is combinational: (if_re & ~if_ready) | ((d_re|d_we) & ~d_ready). It is 0 under reset.
- A request arriving while busy waits; no queueing beyond the held request lines.

Decomposition:
- Shared package define.vh gains:
  - state encodings ArbIdle, ArbIssue, ArbWait, ArbDone and ArbStateBus;
  - grant encodings GntIf, GntData.
- One natural sub-module: arb_lat_cnt, the loadable down-counter with zero flag used in WAIT.
- Grant logic and FSM stay in bus_arb.

Test Plan:
- Fetch only, MEM_LAT=1:
  - Stimulus: if_re=1, if_addr=0x100, memory returns 0x00500093.
  - Response: m_en=1 at cycle 1 with m_addr=0x100; if_ready=1 and if_rdata=0x00500093 at cycle 3.
  - stallreq_o=1 in cycles 0-2 and 0 in cycle 3.
- Write: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> single m_en with m_we=1, m_addr=0x20, m_wdata=0xDEADBEEF; d_ready pulse 2 cycles after the request; if_ready stays 0.
- Simultaneous requests: if_re=1 and d_re=1 at the same cycle -> data granted first with d_ready at cycle 3; fetch issues at cycle 5 with if_ready at cycle 7 (MEM_LAT=1).
- Starvation, STARVE_MAX=4: if_re held 1 with back-to-back data reads -> exactly 4 data grants, then a fetch grant, then data again; starve_cnt returns to 0 after the fetch.
- Latency sweep, MEM_LAT=3: read to address 0x40 -> d_ready exactly 5 cycles after the request; d_rdata equals m_rdata sampled 3 cycles after m_en.
- Reset mid-access: assert rst=0 during WAIT -> all outputs 0 immediately; after release, with no requests, no ready pulse occurs and m_en stays 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state and grant encodings.
package bus_arb_pkg;

  localparam int ArbStateBus = 2;
  localparam int LatCntW     = 3;

  typedef enum logic [ArbStateBus-1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2,
    ArbDone  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GntIf   = 1'b0,
    GntData = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/bus_arb_lat_cnt.sv
// Loadable down-counter with zero flag, used to time out memory read latency.
module arb_lat_cnt
  import bus_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LatCntW-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [LatCntW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - LatCntW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bus_arb.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and data accesses.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stallreq_o
);

  localparam int StW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [StW-1:0]     StarveTop = StW'(STARVE_MAX);
  localparam logic [LatCntW-1:0] LatLoad   = LatCntW'(MEM_LAT - 1);

  function automatic logic [StW-1:0] sat_inc(input logic [StW-1:0] v);
    return (v == StarveTop) ? v : v + StW'(1);
  endfunction

  arb_state_e              state, state_nxt;
  arb_gnt_e                gnt_p0;
  logic                    we_p0;
  logic [ADDR_W-1:0]       addr_p0;
  logic [DATA_W-1:0]       wdata_p0;
  logic [DATA_W-1:0]       if_rdata_p1, d_rdata_p1;
  logic [StW-1:0]          starve_cnt;
  logic                    d_req, fetch_win, grant;
  logic                    lat_load, lat_dec, lat_zero, capture;

  assign d_req     = d_re | d_we;
  assign fetch_win = if_re & (~d_req | (starve_cnt == StarveTop));
  assign grant     = (state == ArbIdle) & (if_re | d_req);

  always_comb begin
    state_nxt = state;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;
    capture   = 1'b0;
    case (state)
      ArbIdle:  if (if_re | d_req) state_nxt = ArbIssue;
      ArbIssue: begin
        if (we_p0) begin
          state_nxt = ArbDone;
        end else begin
          state_nxt = ArbWait;
          lat_load  = 1'b1;
        end
      end
      ArbWait: begin
        lat_dec = 1'b1;
        if (lat_zero) begin
          state_nxt = ArbDone;
          capture   = 1'b1;
        end
      end
      ArbDone:  state_nxt = ArbIdle;
      default:  state_nxt = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ArbIdle;
      gnt_p0     <= GntIf;
      we_p0      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_p0 <= fetch_win ? GntIf : GntData;
        we_p0  <= ~fetch_win & d_we;
        // Fairness: only data grants that overtake a waiting fetch count toward starvation.
        if (fetch_win || !if_re) starve_cnt <= '0;
        else                     starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

  // Stage p0: address and store data latched at grant.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_p0  <= fetch_win ? if_addr : d_addr;
      wdata_p0 <= fetch_win ? '0 : d_wdata;
    end
  end

  // Stage p1: read data captured on the last latency cycle; held between accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_p1 <= '0;
      d_rdata_p1  <= '0;
    end else if (capture) begin
      if (gnt_p0 == GntIf) if_rdata_p1 <= m_rdata;
      else                 d_rdata_p1  <= m_rdata;
    end
  end

  arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LatLoad),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  assign m_en     = (state == ArbIssue);
  assign m_we     = m_en & we_p0;
  assign m_addr   = m_en ? addr_p0 : '0;
  assign m_wdata  = m_we ? wdata_p0 : '0;
  assign if_ready = (state == ArbDone) & (gnt_p0 == GntIf);
  assign d_ready  = (state == ArbDone) & (gnt_p0 == GntData);
  assign if_rdata = if_rdata_p1;
  assign d_rdata  = d_rdata_p1;

  assign stallreq_o = rst & ((if_re & ~if_ready) | (d_req & ~d_ready));

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: directed timing scenarios plus randomized traffic against a transaction-level memory model.
module tb_bus_arb;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_re, d_re, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        if_ready, d_ready, m_en, m_we, stallreq_o;

  logic        d_re3;
  logic [31:0] d_addr3;
  logic [31:0] if_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
  logic        if_ready3, d_ready3, m_en3, m_we3, stallreq3;

  int n_tests, n_fail;

  bus_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_re(if_re), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stallreq_o(stallreq_o)
  );

  bus_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_re(1'b0), .if_addr(32'h0), .if_rdata(if_rdata3), .if_ready(if_ready3),
    .d_re(d_re3), .d_we(1'b0), .d_addr(d_addr3), .d_wdata(32'h0),
    .d_rdata(d_rdata3), .d_ready(d_ready3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
    .stallreq_o(stallreq3)
  );

  // Unwritten words read a fixed per-address pattern.
  function automatic logic [31:0] init_val(input logic [7:0] idx);
    if (idx == 8'd64) return 32'h00500093;
    return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
  endfunction

  logic [31:0] mem [256];
  bit          mem_wr [256];
  bit   [7:0]  rd_idx;
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        mem[m_addr[9:2]]    <= m_wdata;
        mem_wr[m_addr[9:2]] <= 1'b1;
      end
      rd_idx <= m_addr[9:2];
    end
  end
  assign m_rdata = mem_wr[rd_idx] ? mem[rd_idx] : init_val(rd_idx);

  // Latency-3 memory returns a value that changes every cycle so the capture cycle is observable.
  bit [15:0] cyc;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign m_rdata3 = {16'hC0DE, cyc};

  logic        tr_men[64], tr_mwe[64], tr_ifr[64], tr_dr[64], tr_st[64];
  logic [31:0] tr_maddr[64], tr_mwdata[64], tr_ifrd[64], tr_drd[64];

  // Records n cycles (sampled at negedge); requesters drop their line after ready unless held.
  task automatic run_cycles(input int n, input bit hold_if, input bit hold_d);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tr_men[k] = m_en;   tr_mwe[k] = m_we;   tr_maddr[k] = m_addr; tr_mwdata[k] = m_wdata;
      tr_ifr[k] = if_ready; tr_ifrd[k] = if_rdata;
      tr_dr[k]  = d_ready;  tr_drd[k]  = d_rdata; tr_st[k] = stallreq_o;
      @(posedge clk); #1;
      if (tr_ifr[k] && !hold_if) if_re = 1'b0;
      if (tr_dr[k] && !hold_d) begin d_re = 1'b0; d_we = 1'b0; end
    end
  endtask

  function automatic int count_men(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (tr_men[k]) c++;
    return c;
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    if_re = 1'b1; d_re = 1'b1; d_we = 1'b1;
    if_addr = 32'h44; d_addr = 32'h48; d_wdata = 32'h1234;
    #2;
    n_tests++;
    if ({m_en, m_we, m_addr, m_wdata, if_ready, if_rdata, d_ready, d_rdata, stallreq_o} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got m_en=%b m_addr=%h stall=%b ready=%b%b, want all 0",
                                m_en, m_addr, stallreq_o, if_ready, d_ready); end
    if_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_cycles(4, 1'b0, 1'b0);
    n_tests++;
    if (count_men(4) != 0 || tr_st[3] !== 1'b0)
      begin n_fail++; $display("FAIL reset_idle: got m_en count=%0d stall=%b, want 0 0", count_men(4), tr_st[3]); end
  endtask

  task automatic test_fetch();
    if_addr = 32'h100; if_re = 1'b1;
    run_cycles(6, 1'b0, 1'b0);
    n_tests++;
    if ({tr_men[0], tr_men[1], tr_men[2], tr_men[3]} !== 4'b0100)
      begin n_fail++; $display("FAIL fetch_m_en: got %b%b%b%b want 0100", tr_men[0], tr_men[1], tr_men[2], tr_men[3]); end
    n_tests++;
    if (tr_maddr[1] !== 32'h100 || tr_mwe[1] !== 1'b0)
      begin n_fail++; $display("FAIL fetch_m_addr: got addr=%h we=%b want 100 0", tr_maddr[1], tr_mwe[1]); end
    n_tests++;
    if ({tr_ifr[2], tr_ifr[3], tr_ifr[4]} !== 3'b010)
      begin n_fail++; $display("FAIL fetch_ready: got %b%b%b (cycles 2..4) want 010", tr_ifr[2], tr_ifr[3], tr_ifr[4]); end
    n_tests++;
    if (tr_ifrd[3] !== 32'h00500093)
      begin n_fail++; $display("FAIL fetch_rdata: got %h want 00500093", tr_ifrd[3]); end
    n_tests++;
    if ({tr_st[0], tr_st[1], tr_st[2], tr_st[3]} !== 4'b1110)
      begin n_fail++; $display("FAIL fetch_stall: got %b%b%b%b want 1110", tr_st[0], tr_st[1], tr_st[2], tr_st[3]); end
  endtask

  task automatic test_write();
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    run_cycles(5, 1'b0, 1'b0);
    n_tests++;
    if ({tr_men[1], tr_mwe[1], tr_maddr[1], tr_mwdata[1]} !== {1'b1, 1'b1, 32'h20, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL write_issue: got en=%b we=%b addr=%h wdata=%h want 1 1 20 deadbeef",
                                tr_men[1], tr_mwe[1], tr_maddr[1], tr_mwdata[1]); end
    n_tests++;
    if ({tr_dr[1], tr_dr[2], tr_dr[3]} !== 3'b010 || count_men(5) != 1)
      begin n_fail++; $display("FAIL write_ready: got ready=%b%b%b m_en count=%0d want 010 1",
                                tr_dr[1], tr_dr[2], tr_dr[3], count_men(5)); end
    n_tests++;
    if ((tr_ifr[0] | tr_ifr[1] | tr_ifr[2] | tr_ifr[3] | tr_ifr[4]) !== 1'b0)
      begin n_fail++; $display("FAIL write_if_ready: got if_ready pulse, want none"); end
  endtask

  task automatic test_simultaneous();
    if_addr = 32'h104; d_addr = 32'h24; if_re = 1'b1; d_re = 1'b1;
    run_cycles(10, 1'b0, 1'b0);
    n_tests++;
    if (tr_dr[3] !== 1'b1 || tr_ifr[3] !== 1'b0 || tr_drd[3] !== init_val(8'd9))
      begin n_fail++; $display("FAIL simul_data: got d_ready=%b if_ready=%b d_rdata=%h want 1 0 %h",
                                tr_dr[3], tr_ifr[3], tr_drd[3], init_val(8'd9)); end
    n_tests++;
    if (tr_men[1] !== 1'b1 || tr_maddr[1] !== 32'h24 || tr_men[5] !== 1'b1 || tr_maddr[5] !== 32'h104 ||
        count_men(10) != 2)
      begin n_fail++; $display("FAIL simul_issue: got c1=%b/%h c5=%b/%h count=%0d want 1/24 1/104 2",
                                tr_men[1], tr_maddr[1], tr_men[5], tr_maddr[5], count_men(10)); end
    n_tests++;
    if (tr_ifr[7] !== 1'b1 || tr_ifr[6] !== 1'b0 || tr_ifrd[7] !== init_val(8'd65))
      begin n_fail++; $display("FAIL simul_fetch: got if_ready c6/c7=%b%b if_rdata=%h want 01 %h",
                                tr_ifr[6], tr_ifr[7], tr_ifrd[7], init_val(8'd65)); end
  endtask

  task automatic test_starvation();
    byte seq[$];
    byte exp_c;
    if_addr = 32'h108; d_addr = 32'h28; if_re = 1'b1; d_re = 1'b1;
    run_cycles(44, 1'b1, 1'b1);
    if_re = 1'b0; d_re = 1'b0;
    for (int k = 0; k < 44; k++) begin
      if (tr_dr[k])  seq.push_back("D");
      if (tr_ifr[k]) seq.push_back("F");
    end
    n_tests++;
    if (seq.size() < 10)
      begin n_fail++; $display("FAIL starve_count: got %0d completions want >= 10", seq.size()); end
    for (int i = 0; i < 10 && i < seq.size(); i++) begin
      exp_c = (i == STARVE_MAX || i == 2 * STARVE_MAX + 1) ? "F" : "D";
      n_tests++;
      if (seq[i] != exp_c)
        begin n_fail++; $display("FAIL starve_order[%0d]: got %c want %c", i, seq[i], exp_c); end
    end
    run_cycles(8, 1'b0, 1'b0);
  endtask

  task automatic test_latency();
    int          en_cyc = -1;
    int          rdy_cyc = -1;
    logic [31:0] exp_rd = '0;
    logic [31:0] got_rd = '0;
    logic [31:0] got_addr = '0;
    d_addr3 = 32'h40; d_re3 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_en3 && en_cyc < 0) begin en_cyc = k; got_addr = m_addr3; end
      if (en_cyc >= 0 && k == en_cyc + 3) exp_rd = m_rdata3;
      if (d_ready3 && rdy_cyc < 0) begin rdy_cyc = k; got_rd = d_rdata3; end
      @(posedge clk); #1;
      if (rdy_cyc == k) d_re3 = 1'b0;
    end
    n_tests++;
    if (en_cyc != 1 || got_addr !== 32'h40)
      begin n_fail++; $display("FAIL lat3_issue: got cycle=%0d addr=%h want 1 40", en_cyc, got_addr); end
    n_tests++;
    if (rdy_cyc != 5)
      begin n_fail++; $display("FAIL lat3_ready_cycle: got %0d want 5", rdy_cyc); end
    n_tests++;
    if (got_rd !== exp_rd)
      begin n_fail++; $display("FAIL lat3_rdata: got %h want %h", got_rd, exp_rd); end
  endtask

  task automatic test_reset_mid();
    d_addr = 32'h2C; d_re = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({m_en, m_we, m_addr, m_wdata, if_ready, if_rdata, d_ready, d_rdata, stallreq_o} !== '0)
      begin n_fail++; $display("FAIL resetmid_outputs: got m_en=%b d_ready=%b d_rdata=%h stall=%b want all 0",
                                m_en, d_ready, d_rdata, stallreq_o); end
    d_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_cycles(8, 1'b0, 1'b0);
    n_tests++;
    if (count_men(8) != 0 || (tr_dr[0] | tr_dr[1] | tr_dr[2] | tr_dr[3] | tr_dr[4] | tr_dr[5] | tr_dr[6] | tr_dr[7]) !== 1'b0
        || tr_drd[7] !== 32'h0)
      begin n_fail++; $display("FAIL resetmid_quiet: got m_en count=%0d d_rdata=%h want 0 0", count_men(8), tr_drd[7]); end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [16];
    bit          ref_wr [16];
    logic [31:0] expv;
    int          if_age = 0, d_age = 0, en_since = 0, d_since_if = 0, n_done = 0, mode;
    bit          drop_if, drop_d, abort = 0;
    for (int i = 0; i < 16; i++) ref_wr[i] = 1'b0;
    for (int c = 0; c < 800 && !abort; c++) begin
      @(negedge clk);
      drop_if = 1'b0; drop_d = 1'b0;
      if (m_en) en_since++;
      if (!if_ready && !d_ready) begin
        n_tests++;
        if (stallreq_o !== (if_re | d_re | d_we))
          begin n_fail++; $display("FAIL rand_stall: got %b want %b at iter %0d", stallreq_o, if_re | d_re | d_we, c); end
      end
      if (if_ready) begin
        expv = ref_wr[if_addr[5:2]] ? ref_mem[if_addr[5:2]] : init_val({4'h8, if_addr[5:2]});
        n_tests++;
        if (!if_re || if_rdata !== expv || en_since != 1)
          begin n_fail++; $display("FAIL rand_fetch: got rdata=%h m_en=%0d req=%b want %h 1 1",
                                    if_rdata, en_since, if_re, expv); end
        n_tests++;
        if (d_since_if > STARVE_MAX + 1)
          begin n_fail++; $display("FAIL rand_starve: got %0d data completions before fetch want <= %0d",
                                    d_since_if, STARVE_MAX + 1); end
        en_since = 0; d_since_if = 0; drop_if = 1'b1; n_done++;
      end
      if (d_ready) begin
        n_tests++;
        if (!(d_re | d_we) || en_since != 1)
          begin n_fail++; $display("FAIL rand_data_txn: got req=%b m_en=%0d want 1 1", d_re | d_we, en_since); end
        if (d_we) begin
          ref_mem[d_addr[5:2]] = d_wdata; ref_wr[d_addr[5:2]] = 1'b1;
        end else begin
          expv = ref_wr[d_addr[5:2]] ? ref_mem[d_addr[5:2]] : init_val({4'h8, d_addr[5:2]});
          n_tests++;
          if (d_rdata !== expv)
            begin n_fail++; $display("FAIL rand_load: got %h want %h addr %h", d_rdata, expv, d_addr); end
        end
        if (if_re) d_since_if++;
        en_since = 0; drop_d = 1'b1; n_done++;
      end
      if (if_re && !drop_if) if_age++; else if_age = 0;
      if ((d_re | d_we) && !drop_d) d_age++; else d_age = 0;
      if (if_age > 48 || d_age > 48) begin
        n_tests++; n_fail++; abort = 1'b1;
        $display("FAIL rand_timeout: got wait if=%0d d=%0d cycles want <= 48", if_age, d_age);
      end
      @(posedge clk); #1;
      if (drop_if) if_re = 1'b0;
      if (drop_d) begin d_re = 1'b0; d_we = 1'b0; end
      if (!if_re && $urandom_range(0, 2) == 0) begin
        if_re = 1'b1; if_addr = 32'h200 + 32'($urandom_range(0, 15)) * 4;
      end
      if (!(d_re | d_we) && $urandom_range(0, 1) == 0) begin
        mode = $urandom_range(0, 2);
        d_addr = 32'h200 + 32'($urandom_range(0, 15)) * 4;
        d_wdata = $urandom; d_re = (mode != 1); d_we = (mode != 0);
      end
    end
    if_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
    run_cycles(8, 1'b0, 1'b0);
    n_tests++;
    if (n_done < 50)
      begin n_fail++; $display("FAIL rand_throughput: got %0d completions want >= 50", n_done); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0;
    if_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    d_re3 = 1'b0; d_addr3 = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_fetch();
    test_write();
    test_simultaneous();
    test_starvation();
    test_latency();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion within time limit want finish");
    $fatal(1, "watchdog");
  end

endmodule
